// File: rtl/activation_pkg.sv
// Shared types and Q-format constant generation for the activation engine.
package activation_pkg;

   typedef enum logic [1:0] {
      ACT_PASS    = 2'd0,
      ACT_RELU    = 2'd1,
      ACT_SIGMOID = 2'd2,
      ACT_TANH    = 2'd3
   } act_mode_e;

   typedef enum logic [1:0] {
      SEG_BELOW_1    = 2'd0,
      SEG_1_TO_2375  = 2'd1,
      SEG_2375_TO_5  = 2'd2,
      SEG_ABOVE_5    = 2'd3
   } act_seg_e;

   typedef enum logic [2:0] {
      QC_ONE     = 3'd0,
      QC_T2375   = 3'd1,
      QC_T5      = 3'd2,
      QC_HALF    = 3'd3,
      QC_O0625   = 3'd4,
      QC_O084375 = 3'd5
   } q_const_e;

   // Fixed-point constants scaled by 2^decimal_width, truncated toward zero.
   function automatic longint q_const(input int decimal_width, input q_const_e which);
      longint one;
      one = longint'(1) << decimal_width;
      case (which)
         QC_ONE:     return one;
         QC_T2375:   return (one * 19) / 8;
         QC_T5:      return one * 5;
         QC_HALF:    return one / 2;
         QC_O0625:   return (one * 5) / 8;
         QC_O084375: return (one * 27) / 32;
         default:    return one;
      endcase
   endfunction

endpackage

// File: rtl/activation_unit_if.sv
// Valid/ready input and output streams of the activation engine.
interface activation_unit_if
   import activation_pkg::*;
#(
   parameter int NUM_LANES = 8,
   parameter int BIT_WIDTH = 32
);
   logic                           in_valid;
   logic                           in_ready;
   act_mode_e                      in_mode;
   logic [NUM_LANES*BIT_WIDTH-1:0] in_data;
   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_LANES*BIT_WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/activation_lane.sv
// One element of the activation pipeline: prep, segment, sigmoid core, post.
// Each stage register only loads when its load bit is set, so a stall or a
// bubble simply leaves the stage contents untouched.
module activation_lane
   import activation_pkg::*;
#(
   parameter int BIT_WIDTH     = 32,
   parameter int DECIMAL_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           load,
   input  act_mode_e            mode,
   input  logic [BIT_WIDTH-1:0] x,
   output logic [BIT_WIDTH-1:0] y
);
   typedef logic [BIT_WIDTH:0]   wide_t;
   typedef logic [BIT_WIDTH-1:0] word_t;

   localparam wide_t ONE      = wide_t'(q_const(DECIMAL_WIDTH, QC_ONE));
   localparam wide_t T2375    = wide_t'(q_const(DECIMAL_WIDTH, QC_T2375));
   localparam wide_t T5       = wide_t'(q_const(DECIMAL_WIDTH, QC_T5));
   localparam wide_t HALF     = wide_t'(q_const(DECIMAL_WIDTH, QC_HALF));
   localparam wide_t O0625    = wide_t'(q_const(DECIMAL_WIDTH, QC_O0625));
   localparam wide_t O084375  = wide_t'(q_const(DECIMAL_WIDTH, QC_O084375));
   localparam wide_t MAX_POS  = {2'b00, {(BIT_WIDTH-1){1'b1}}};

   act_mode_e s1_mode, s2_mode, s3_mode;
   logic      s1_sign, s2_sign, s3_sign;
   wide_t     s1_a, s2_a, s3_y;
   word_t     s1_x, s2_x, s3_x;
   act_seg_e  s2_seg;

   wide_t     abs_x, abs_sat, abs_dbl, a_next;
   act_seg_e  seg_next;
   wide_t     y_next, sig_s, res;

   // S1: saturating magnitude, doubled and re-clamped for tanh.
   always_comb begin
      abs_x   = x[BIT_WIDTH-1] ? -{x[BIT_WIDTH-1], x} : {1'b0, x};
      abs_sat = (abs_x > MAX_POS) ? MAX_POS : abs_x;
      abs_dbl = abs_sat << 1;
      a_next  = abs_sat;
      if (mode == ACT_TANH) begin
         a_next = (abs_dbl > MAX_POS) ? MAX_POS : abs_dbl;
      end
   end

   // S2: pick the segment; a value on a threshold belongs to the upper one.
   always_comb begin
      seg_next = SEG_BELOW_1;
      if (s1_a >= T5) begin
         seg_next = SEG_ABOVE_5;
      end else if (s1_a >= T2375) begin
         seg_next = SEG_2375_TO_5;
      end else if (s1_a >= ONE) begin
         seg_next = SEG_1_TO_2375;
      end
   end

   // S3: piecewise-linear sigmoid of the magnitude using shifts and adds.
   always_comb begin
      y_next = (s2_a >> 2) + HALF;
      case (s2_seg)
         SEG_ABOVE_5:   y_next = ONE;
         SEG_2375_TO_5: y_next = (s2_a >> 5) + O084375;
         SEG_1_TO_2375: y_next = (s2_a >> 3) + O0625;
         default:       y_next = (s2_a >> 2) + HALF;
      endcase
   end

   // S4: fold the sign back in and map to the requested activation.
   always_comb begin
      sig_s = s3_sign ? (ONE - s3_y) : s3_y;
      res   = {s3_x[BIT_WIDTH-1], s3_x};
      case (s3_mode)
         ACT_SIGMOID: res = sig_s;
         ACT_TANH:    res = (sig_s << 1) - ONE;
         ACT_RELU:    res = s3_sign ? '0 : {s3_x[BIT_WIDTH-1], s3_x};
         default:     res = {s3_x[BIT_WIDTH-1], s3_x};
      endcase
   end

   // Stage registers; reset clears everything so the output reads zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_mode <= ACT_PASS;
         s1_sign <= 1'b0;
         s1_a    <= '0;
         s1_x    <= '0;
         s2_mode <= ACT_PASS;
         s2_sign <= 1'b0;
         s2_a    <= '0;
         s2_x    <= '0;
         s2_seg  <= SEG_BELOW_1;
         s3_mode <= ACT_PASS;
         s3_sign <= 1'b0;
         s3_y    <= '0;
         s3_x    <= '0;
         y       <= '0;
      end else begin
         if (load[0]) begin
            s1_mode <= mode;
            s1_sign <= x[BIT_WIDTH-1];
            s1_a    <= a_next;
            s1_x    <= x;
         end
         if (load[1]) begin
            s2_mode <= s1_mode;
            s2_sign <= s1_sign;
            s2_a    <= s1_a;
            s2_x    <= s1_x;
            s2_seg  <= seg_next;
         end
         if (load[2]) begin
            s3_mode <= s2_mode;
            s3_sign <= s2_sign;
            s3_y    <= y_next;
            s3_x    <= s2_x;
         end
         if (load[3]) begin
            y <= word_t'(res);
         end
      end
   end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane pipelined activation engine with valid/ready back-pressure.
// A single global stall freezes every stage whenever the output is held.
module activation_unit
   import activation_pkg::*;
#(
   parameter int NUM_LANES     = 8,
   parameter int BIT_WIDTH     = 32,
   parameter int DECIMAL_WIDTH = 16,
   parameter int LATENCY       = 4
) (
   input logic               clk,
   input logic               reset,
   activation_unit_if.slave  bus
);
   localparam int STAGES = 4;

   if (LATENCY != STAGES) begin : g_latency_check
      $error("activation_unit: LATENCY must be 4");
   end

   logic [STAGES-1:0]              stage_valid;
   logic [STAGES-1:0]              load;
   logic                           stall;
   logic [NUM_LANES*BIT_WIDTH-1:0] lane_y;

   assign stall         = stage_valid[STAGES-1] & ~bus.out_ready;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = stage_valid[STAGES-1];
   assign bus.out_data  = lane_y;
   assign load          = {stage_valid[2:0] & {3{~stall}}, bus.in_valid & ~stall};

   // Stage-valid shift register; advances only when the output is not held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_valid <= '0;
      end else if (!stall) begin
         stage_valid <= {stage_valid[STAGES-2:0], bus.in_valid};
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      activation_lane #(
         .BIT_WIDTH     (BIT_WIDTH),
         .DECIMAL_WIDTH (DECIMAL_WIDTH)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .load  (load),
         .mode  (bus.in_mode),
         .x     (bus.in_data[i*BIT_WIDTH +: BIT_WIDTH]),
         .y     (lane_y[i*BIT_WIDTH +: BIT_WIDTH])
      );
   end

endmodule

// File: doc/activation_unit.md
Name: activation_unit

Overview:
- Parametrised, multi-lane, pipelined fixed-point activation engine for the SIMD datapath. Successor to the single-lane tanh-only unit.
- Selects among pass-through, ReLU, sigmoid and tanh per transaction. Operates on NUM_LANES signed Q(BIT_WIDTH-DECIMAL_WIDTH).DECIMAL_WIDTH words in parallel.
- Adds valid/ready handshaking with full back-pressure, so it drops between the vector register read and the writeback FIFO.

Parameters:
- NUM_LANES, 8, number of parallel elements per beat.
- BIT_WIDTH, 32, width of each element (two's complement).
- DECIMAL_WIDTH, 16, fractional bits; ONE = 2^DECIMAL_WIDTH.
- LATENCY, 4, fixed pipeline depth in cycles (localparam-checked; must equal 4).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset; sampled on the clk rising edge, 0 = reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, unit accepts a beat this cycle.
- in_mode, input, 2, activation select: 0 pass, 1 ReLU, 2 sigmoid, 3 tanh.
- in_data, input, NUM_LANES*BIT_WIDTH, lane i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, NUM_LANES*BIT_WIDTH, results in the same lane order.

Behaviour:
- **Reset.** All stage-valid bits clear. out_valid=0, out_data=0. in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats; no partial output is emitted.
- **Handshake.**
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - in_mode and in_data are sampled only on an input transfer.
- **Pipeline.**
  - Stage registers S1..S4, each with a valid bit. Global stall = out_valid & ~out_ready.
  - On stall, every stage holds its contents. in_ready = ~stall, so there are no bubbles when out_ready=1.
  - out_data/out_valid are held stable while stalled.
  - Latency: a beat accepted at cycle t appears on out_valid at cycle t+4 if there is no stall.
  - Throughput: 1 beat/cycle.
- **S1 (prep).** Latch mode and, per lane, sign = x[MSB].
  - a = |x|; for x = most-negative, a = max positive (saturate).
  - For tanh, a = sat(2·a), clamped to max positive.
- **S2 (segment).** Classify a against 1.0, 2.375 and 5.0 (each scaled by ONE). Register the segment index and a.
- **S3 (PLAN sigmoid core).** Shift/add only, no multipliers:
  - a ≥ 5.0: y = ONE.
  - 2.375 ≤ a < 5.0: y = (a>>5) + 0.84375·ONE.
  - 1.0 ≤ a < 2.375: y = (a>>3) + 0.625·ONE.
  - a < 1.0: y = (a>>2) + 0.5·ONE.
  - Constants are truncated to an integer at elaboration.
- **S4 (post).** Let s = sign ? ONE−y : y (sigmoid of the signed input).
  - sigmoid: out = s.
  - tanh: out = 2·s − ONE, which lies in [−ONE, ONE].
  - ReLU: out = sign ? 0 : x.
  - pass: out = x.
  - Original x is carried down the pipeline for the ReLU/pass modes.
- **Width rules.**
  - Intermediates are BIT_WIDTH+1 bits; final results fit in BIT_WIDTH.
  - Sigmoid output is in [0, ONE].
  - All right shifts are arithmetic on non-negative values (truncate).
- **Boundaries.**
  - Input exactly on a segment threshold takes the upper segment.
  - x = 0 gives sigmoid ONE/2 and tanh 0.
  - Lanes are fully independent; mode is common to all lanes of a beat.
  - Consecutive beats may differ in mode.

Decomposition:
- Package activation_pkg:
  - mode enum (ACT_PASS, ACT_RELU, ACT_SIGMOID, ACT_TANH).
  - Segment enum.
  - Function computing the Q-format constants (thresholds 1.0/2.375/5.0, offsets 0.5/0.625/0.84375) from DECIMAL_WIDTH.
- One sub-module activation_lane: single-element datapath for S1–S4 with a stall/enable input.
- The top holds the valid/stall control and generates NUM_LANES lanes.

Test Plan:
All values use defaults (Q16.16, ONE=65536).
- sigmoid, lane0 = 0, 65536, −65536, 131072 → out 32768, 49152, 16384, 57344 exactly 4 cycles after acceptance.
- tanh, lanes = 32768, 0, −196608, 0x80000000 → 32768, 0, −65536, −65536.
- ReLU/pass mixed: ReLU beat {−327680, 100} → {0, 100}, then next cycle a pass beat {−327680} → {−327680}; results are back-to-back on out_valid.
- Back-pressure: stream 10 sigmoid beats with a 0.5 ramp, holding out_ready=0 for cycles 6–9.
  - in_ready falls exactly while out_valid & ~out_ready.
  - No beat is lost or duplicated; order is preserved; out_data is stable during the stall.
- Reset mid-stream: assert reset=0 with 3 beats in flight → next cycle out_valid=0, out_data=0. After release, the first new beat emerges after 4 cycles with the correct value.
- Random sweep, all modes and lanes, random in_valid/out_ready → matches a bit-exact PLAN reference model; zero mismatches over 10k beats.
